// File: rtl/hazard_tag_pipeline.sv
// Hazard tag pipeline: carries register tags and hazard-relevant control bits
// through the Execute, Memory and Writeback stages. It also produces the
// source/destination match flags that the hazard unit consumes.
module hazard_tag_pipeline #(
  parameter int REG_ADDR_W = 4,
  parameter int PC_REG     = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] RA1D,
  input  logic [REG_ADDR_W-1:0] RA2D,
  input  logic [REG_ADDR_W-1:0] WA3D,
  input  logic                  UseRA1D,
  input  logic                  UseRA2D,
  input  logic                  RegWriteD,
  input  logic                  MemToRegD,
  input  logic                  PCSrcD,
  input  logic                  CondExE,
  input  logic                  FlushE,
  output logic                  Match_1E_M,
  output logic                  Match_1E_W,
  output logic                  Match_2E_M,
  output logic                  Match_2E_W,
  output logic                  Match_12D_E,
  output logic                  RegWriteM,
  output logic                  RegWriteW,
  output logic                  MemToRegE,
  output logic                  PCSrcE,
  output logic                  PCSrcM,
  output logic                  PCSrcW
);

  localparam logic [REG_ADDR_W-1:0] PC_TAG = REG_ADDR_W'(PC_REG);

  // A source matches a destination only when it is really read and is not the PC.
  function automatic logic src_match(input logic                  rd_en,
                                     input logic [REG_ADDR_W-1:0] src,
                                     input logic [REG_ADDR_W-1:0] dst);
    return rd_en & (src != PC_TAG) & (src == dst);
  endfunction

  // Execute stage state
  logic [REG_ADDR_W-1:0] ra1_e_q, ra1_e_d;
  logic [REG_ADDR_W-1:0] ra2_e_q, ra2_e_d;
  logic [REG_ADDR_W-1:0] wa3_e_q, wa3_e_d;
  logic                  use1_e_q, use1_e_d;
  logic                  use2_e_q, use2_e_d;
  logic                  regwr_e_q, regwr_e_d;
  logic                  mem2reg_e_q, mem2reg_e_d;
  logic                  pcsrc_e_q, pcsrc_e_d;

  // Memory stage state (load flag is not needed past Execute by any consumer)
  logic [REG_ADDR_W-1:0] wa3_m_q, wa3_m_d;
  logic                  regwr_m_q, regwr_m_d;
  logic                  pcsrc_m_q, pcsrc_m_d;

  // Writeback stage state
  logic [REG_ADDR_W-1:0] wa3_w_q, wa3_w_d;
  logic                  regwr_w_q, regwr_w_d;
  logic                  pcsrc_w_q, pcsrc_w_d;

  // Next-state: E takes decode or a bubble on flush; M/W always advance, M gated by condition.
  always_comb begin
    ra1_e_d     = RA1D;
    ra2_e_d     = RA2D;
    wa3_e_d     = WA3D;
    use1_e_d    = UseRA1D;
    use2_e_d    = UseRA2D;
    regwr_e_d   = RegWriteD;
    mem2reg_e_d = MemToRegD;
    pcsrc_e_d   = PCSrcD;
    if (FlushE) begin
      ra1_e_d     = '0;
      ra2_e_d     = '0;
      wa3_e_d     = '0;
      use1_e_d    = 1'b0;
      use2_e_d    = 1'b0;
      regwr_e_d   = 1'b0;
      mem2reg_e_d = 1'b0;
      pcsrc_e_d   = 1'b0;
    end
    // A failed condition turns the instruction into a no-write; its tag still moves on.
    wa3_m_d   = wa3_e_q;
    regwr_m_d = regwr_e_q & CondExE;
    pcsrc_m_d = pcsrc_e_q & CondExE;
    wa3_w_d   = wa3_m_q;
    regwr_w_d = regwr_m_q;
    pcsrc_w_d = pcsrc_m_q;
  end

  // Stage registers; reset discards every in-flight instruction, including tags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ra1_e_q     <= '0;
      ra2_e_q     <= '0;
      wa3_e_q     <= '0;
      use1_e_q    <= 1'b0;
      use2_e_q    <= 1'b0;
      regwr_e_q   <= 1'b0;
      mem2reg_e_q <= 1'b0;
      pcsrc_e_q   <= 1'b0;
      wa3_m_q     <= '0;
      regwr_m_q   <= 1'b0;
      pcsrc_m_q   <= 1'b0;
      wa3_w_q     <= '0;
      regwr_w_q   <= 1'b0;
      pcsrc_w_q   <= 1'b0;
    end else begin
      ra1_e_q     <= ra1_e_d;
      ra2_e_q     <= ra2_e_d;
      wa3_e_q     <= wa3_e_d;
      use1_e_q    <= use1_e_d;
      use2_e_q    <= use2_e_d;
      regwr_e_q   <= regwr_e_d;
      mem2reg_e_q <= mem2reg_e_d;
      pcsrc_e_q   <= pcsrc_e_d;
      wa3_m_q     <= wa3_m_d;
      regwr_m_q   <= regwr_m_d;
      pcsrc_m_q   <= pcsrc_m_d;
      wa3_w_q     <= wa3_w_d;
      regwr_w_q   <= regwr_w_d;
      pcsrc_w_q   <= pcsrc_w_d;
    end
  end

  // Match flags are ungated by RegWrite; the hazard unit qualifies them.
  always_comb begin
    Match_1E_M  = src_match(use1_e_q, ra1_e_q, wa3_m_q);
    Match_1E_W  = src_match(use1_e_q, ra1_e_q, wa3_w_q);
    Match_2E_M  = src_match(use2_e_q, ra2_e_q, wa3_m_q);
    Match_2E_W  = src_match(use2_e_q, ra2_e_q, wa3_w_q);
    Match_12D_E = src_match(UseRA1D, RA1D, wa3_e_q) | src_match(UseRA2D, RA2D, wa3_e_q);
  end

  assign RegWriteM = regwr_m_q;
  assign RegWriteW = regwr_w_q;
  assign MemToRegE = mem2reg_e_q;
  assign PCSrcE    = pcsrc_e_q;
  assign PCSrcM    = pcsrc_m_q;
  assign PCSrcW    = pcsrc_w_q;

endmodule

// File: tb/tb_hazard_tag_pipeline.sv
// Directed bench for hazard_tag_pipeline with hand-computed expectations.
module tb_hazard_tag_pipeline;

  logic       clk;
  logic       rst;
  logic [3:0] RA1D, RA2D, WA3D;
  logic       UseRA1D, UseRA2D, RegWriteD, MemToRegD, PCSrcD, CondExE, FlushE;
  logic       Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
  logic       RegWriteM, RegWriteW, MemToRegE, PCSrcE, PCSrcM, PCSrcW;

  int total = 0;
  int bad   = 0;

  hazard_tag_pipeline #(.REG_ADDR_W(4), .PC_REG(15)) dut (
    .clk(clk), .rst(rst),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .UseRA1D(UseRA1D), .UseRA2D(UseRA2D),
    .RegWriteD(RegWriteD), .MemToRegD(MemToRegD), .PCSrcD(PCSrcD),
    .CondExE(CondExE), .FlushE(FlushE),
    .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
    .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W),
    .Match_12D_E(Match_12D_E),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemToRegE(MemToRegE),
    .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_d();
    RA1D = 4'd0; RA2D = 4'd0; WA3D = 4'd0;
    UseRA1D = 1'b0; UseRA2D = 1'b0;
    RegWriteD = 1'b0; MemToRegD = 1'b0; PCSrcD = 1'b0;
  endtask

  task automatic drain();
    clr_d();
    tick(); tick(); tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m1em"}, Match_1E_M, 1'b0);
    chk({tag, "_m1ew"}, Match_1E_W, 1'b0);
    chk({tag, "_m2em"}, Match_2E_M, 1'b0);
    chk({tag, "_m2ew"}, Match_2E_W, 1'b0);
    chk({tag, "_m12de"}, Match_12D_E, 1'b0);
    chk({tag, "_rwm"}, RegWriteM, 1'b0);
    chk({tag, "_rww"}, RegWriteW, 1'b0);
    chk({tag, "_m2re"}, MemToRegE, 1'b0);
    chk({tag, "_pce"}, PCSrcE, 1'b0);
    chk({tag, "_pcm"}, PCSrcM, 1'b0);
    chk({tag, "_pcw"}, PCSrcW, 1'b0);
  endtask

  initial begin
    clr_d();
    CondExE = 1'b1;
    FlushE  = 1'b0;
    rst     = 1'b0;

    // Reset held two edges with a writing instruction on decode
    RegWriteD = 1'b1; WA3D = 4'd3;
    tick(); tick();
    chk_all_zero("rst");
    rst = 1'b1;
    tick();
    chk("rst_rel1_rwm", RegWriteM, 1'b0);
    tick();
    chk("rst_rel2_rwm", RegWriteM, 1'b1);
    drain();

    // Forwarding: ADD R3, then two readers of R3 (RA2=6 does not match)
    WA3D = 4'd3; RegWriteD = 1'b1;
    tick();
    clr_d();
    RA1D = 4'd3; UseRA1D = 1'b1; RA2D = 4'd6; UseRA2D = 1'b1;
    WA3D = 4'd4; RegWriteD = 1'b1;
    #1;
    chk("fwd_m12de", Match_12D_E, 1'b1);
    tick();
    chk("fwd_m1em", Match_1E_M, 1'b1);
    chk("fwd_rwm", RegWriteM, 1'b1);
    chk("fwd_m1ew_pre", Match_1E_W, 1'b0);
    chk("fwd_m2em", Match_2E_M, 1'b0);
    tick();
    chk("fwd_m1ew", Match_1E_W, 1'b1);
    chk("fwd_rww", RegWriteW, 1'b1);
    chk("fwd_m1em_next", Match_1E_M, 1'b0);
    drain();

    // Source-2 forwarding: writer of R6, reader with RA2=6 only
    WA3D = 4'd6; RegWriteD = 1'b1;
    tick();
    clr_d();
    RA1D = 4'd6; UseRA1D = 1'b0; RA2D = 4'd6; UseRA2D = 1'b1;
    tick();
    chk("src2_m2em", Match_2E_M, 1'b1);
    chk("src2_m1em", Match_1E_M, 1'b0);
    clr_d();
    tick();
    chk("src2_m2ew_bubble", Match_2E_W, 1'b0);
    drain();

    // Load-use with a one-edge flush
    WA3D = 4'd5; MemToRegD = 1'b1; RegWriteD = 1'b1;
    tick();
    clr_d();
    RA2D = 4'd5; UseRA2D = 1'b1; RA1D = 4'd2; UseRA1D = 1'b1;
    #1;
    chk("ldu_m2re", MemToRegE, 1'b1);
    chk("ldu_m12de", Match_12D_E, 1'b1);
    FlushE = 1'b1;
    tick();
    FlushE = 1'b0;
    chk("ldu_fl_m2re", MemToRegE, 1'b0);
    chk("ldu_fl_m1em", Match_1E_M, 1'b0);
    chk("ldu_fl_m2em", Match_2E_M, 1'b0);
    chk("ldu_fl_m1ew", Match_1E_W, 1'b0);
    chk("ldu_fl_m2ew", Match_2E_W, 1'b0);
    chk("ldu_fl_rwm", RegWriteM, 1'b1);
    drain();

    // PC exclusion and use-bit gating
    WA3D = 4'd15;
    tick();
    clr_d();
    RA1D = 4'd15; UseRA1D = 1'b1;
    #1;
    chk("pc_m12de", Match_12D_E, 1'b0);
    tick();
    chk("pc_m1em", Match_1E_M, 1'b0);
    clr_d();
    WA3D = 4'd7;
    tick();
    clr_d();
    RA2D = 4'd7; UseRA2D = 1'b0;
    #1;
    chk("use0_m12de", Match_12D_E, 1'b0);
    UseRA2D = 1'b1;
    #1;
    chk("use1_m12de", Match_12D_E, 1'b1);
    drain();

    // Branch tracking, condition passes
    PCSrcD = 1'b1;
    tick();
    clr_d();
    chk("br_c1_pce", PCSrcE, 1'b1);
    chk("br_c1_pcm", PCSrcM, 1'b0);
    chk("br_c1_pcw", PCSrcW, 1'b0);
    tick();
    chk("br_c2_pce", PCSrcE, 1'b0);
    chk("br_c2_pcm", PCSrcM, 1'b1);
    chk("br_c2_pcw", PCSrcW, 1'b0);
    tick();
    chk("br_c3_pcm", PCSrcM, 1'b0);
    chk("br_c3_pcw", PCSrcW, 1'b1);
    tick();
    chk("br_c4_pcw", PCSrcW, 1'b0);

    // Branch tracking, condition fails
    CondExE = 1'b0;
    PCSrcD = 1'b1;
    tick();
    clr_d();
    chk("brn_c1_pce", PCSrcE, 1'b1);
    tick();
    chk("brn_c2_pcm", PCSrcM, 1'b0);
    tick();
    chk("brn_c3_pcw", PCSrcW, 1'b0);
    CondExE = 1'b1;
    drain();

    // Reset mid-flight: W=R1, M=R2, E reads R2 and R1 and writes R3
    RegWriteD = 1'b1; PCSrcD = 1'b1; WA3D = 4'd1;
    tick();
    WA3D = 4'd2;
    tick();
    WA3D = 4'd3; RA1D = 4'd2; UseRA1D = 1'b1; RA2D = 4'd1; UseRA2D = 1'b1;
    tick();
    clr_d();
    RA1D = 4'd3; UseRA1D = 1'b1;
    #1;
    chk("mid_pre_m1em", Match_1E_M, 1'b1);
    chk("mid_pre_m2ew", Match_2E_W, 1'b1);
    chk("mid_pre_rwm", RegWriteM, 1'b1);
    chk("mid_pre_rww", RegWriteW, 1'b1);
    chk("mid_pre_m12de", Match_12D_E, 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk_all_zero("mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
